// File: rtl/vending_machine_param.sv
// Parametrised vending controller: credit accumulator, four coin values,
// binary change, cancel/refund, coin reject and stock tracking with sold-out lockout.
module vending_machine_param #(
   parameter int CREDIT_W   = 8,
   parameter int PRICE      = 40,
   parameter int COIN0      = 10,
   parameter int COIN1      = 20,
   parameter int COIN2      = 50,
   parameter int COIN3      = 100,
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 8
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [1:0]          Money,
   input  logic                Coin_Valid,
   input  logic                Cancel,
   input  logic                Restock,
   output logic                Z,
   output logic                Change,
   output logic [CREDIT_W-1:0] Change_Amt,
   output logic [CREDIT_W-1:0] Credit,
   output logic                Coin_Reject,
   output logic                Sold_Out,
   output logic                Busy
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_VEND    = 2'd2;
   localparam logic [1:0] S_REFUND  = 2'd3;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   localparam int MAX_COIN = max4(COIN0, COIN1, COIN2, COIN3);

   // Largest value ever held is an almost-complete credit plus the biggest coin.
   generate
      if (longint'(PRICE) - 1 + longint'(MAX_COIN) >= (longint'(1) << CREDIT_W)) begin : g_credit_w_chk
         $error("CREDIT_W too narrow for PRICE - 1 + max coin value");
      end
      if (longint'(STOCK_INIT) >= (longint'(1) << STOCK_W)) begin : g_stock_w_chk
         $error("STOCK_W too narrow for STOCK_INIT");
      end
   endgenerate

   localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);
   localparam logic [STOCK_W-1:0]  STOCK_V = STOCK_W'(STOCK_INIT);
   localparam logic                SOLD_OUT_RST = (STOCK_INIT == 0);

   logic [1:0]          state, state_n;
   logic [CREDIT_W-1:0] credit_n;
   logic [STOCK_W-1:0]  stock, stock_n, stock_base;
   logic [CREDIT_W-1:0] coin_val, sum;
   logic                coin_ok, cancel_eff;
   logic                z_n, chg_n, rej_n, busy_n;
   logic [CREDIT_W-1:0] amt_n;

   // Decode the presented coin code into its currency value.
   always_comb begin
      coin_val = '0;
      case (Money)
         2'b00:   coin_val = CREDIT_W'(COIN0);
         2'b01:   coin_val = CREDIT_W'(COIN1);
         2'b10:   coin_val = CREDIT_W'(COIN2);
         default: coin_val = CREDIT_W'(COIN3);
      endcase
   end

   // Next-state, credit, stock and output decisions for the coming edge.
   always_comb begin
      coin_ok    = Coin_Valid && (state == S_IDLE || state == S_COLLECT) && !Sold_Out;
      sum        = Credit + (coin_ok ? coin_val : '0);
      cancel_eff = Cancel && (state == S_COLLECT || coin_ok);
      stock_base = (Restock && state == S_IDLE) ? STOCK_V : stock;
      state_n    = state;
      credit_n   = Credit;
      stock_n    = stock_base;
      z_n        = 1'b0;
      chg_n      = 1'b0;
      amt_n      = '0;
      rej_n      = Coin_Valid && !coin_ok;
      case (state)
         S_IDLE, S_COLLECT: begin
            if (cancel_eff) begin
               // Cancel beats a completing coin: everything inserted goes back.
               state_n  = S_REFUND;
               credit_n = sum;
               chg_n    = 1'b1;
               amt_n    = sum;
            end else if (coin_ok) begin
               if (sum >= PRICE_V) begin
                  state_n  = S_VEND;
                  credit_n = sum;
                  z_n      = 1'b1;
                  chg_n    = (sum > PRICE_V);
                  amt_n    = (sum > PRICE_V) ? (sum - PRICE_V) : '0;
                  if (stock_base != '0)
                     stock_n = stock_base - STOCK_W'(1);
               end else begin
                  state_n  = S_COLLECT;
                  credit_n = sum;
               end
            end
         end
         default: begin
            state_n  = S_IDLE;
            credit_n = '0;
         end
      endcase
      busy_n = (state_n == S_VEND) || (state_n == S_REFUND);
   end

   // State and registered outputs; reset discards any credit without refunding it.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= S_IDLE;
         Credit      <= '0;
         stock       <= STOCK_V;
         Z           <= 1'b0;
         Change      <= 1'b0;
         Change_Amt  <= '0;
         Coin_Reject <= 1'b0;
         Busy        <= 1'b0;
         Sold_Out    <= SOLD_OUT_RST;
      end else begin
         state       <= state_n;
         Credit      <= credit_n;
         stock       <= stock_n;
         Z           <= z_n;
         Change      <= chg_n;
         Change_Amt  <= amt_n;
         Coin_Reject <= rej_n;
         Busy        <= busy_n;
         Sold_Out    <= (stock == '0);
      end
   end

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed self-checking bench for vending_machine_param (default build plus a
// one-item-stock build for the sold-out / restock path).
module tb_vending_machine_param;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [1:0] Money;
   logic       Coin_Valid, Cancel, Restock;

   logic       z, change, coin_reject, sold_out, busy;
   logic [7:0] change_amt, credit;
   logic       z1, change1, coin_reject1, sold_out1, busy1;
   logic [7:0] change_amt1, credit1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   vending_machine_param dut (
      .Clk(Clk), .Reset(Reset), .Money(Money), .Coin_Valid(Coin_Valid),
      .Cancel(Cancel), .Restock(Restock), .Z(z), .Change(change),
      .Change_Amt(change_amt), .Credit(credit), .Coin_Reject(coin_reject),
      .Sold_Out(sold_out), .Busy(busy)
   );

   vending_machine_param #(.STOCK_INIT(1)) dut1 (
      .Clk(Clk), .Reset(Reset), .Money(Money), .Coin_Valid(Coin_Valid),
      .Cancel(Cancel), .Restock(Restock), .Z(z1), .Change(change1),
      .Change_Amt(change_amt1), .Credit(credit1), .Coin_Reject(coin_reject1),
      .Sold_Out(sold_out1), .Busy(busy1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic coin(input logic [1:0] code);
      Money      = code;
      Coin_Valid = 1'b1;
      tick();
      Coin_Valid = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; Money = 2'b00; Coin_Valid = 1'b0; Cancel = 1'b0; Restock = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      check("rst_z", 32'(z), 0);
      check("rst_change", 32'(change), 0);
      check("rst_amt", 32'(change_amt), 0);
      check("rst_credit", 32'(credit), 0);
      check("rst_reject", 32'(coin_reject), 0);
      check("rst_soldout", 32'(sold_out), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_soldout1", 32'(sold_out1), 0);
      Reset = 1'b0;

      // 10 + 10 + 20 = exact price
      coin(2'b00); check("c10_credit", 32'(credit), 10);
      coin(2'b00); check("c20_credit", 32'(credit), 20);
      coin(2'b01);
      check("exact_z", 32'(z), 1);
      check("exact_change", 32'(change), 0);
      check("exact_credit", 32'(credit), 40);
      check("exact_busy", 32'(busy), 1);
      tick();
      check("exact_z_after", 32'(z), 0);
      check("exact_credit_after", 32'(credit), 0);
      check("exact_busy_after", 32'(busy), 0);

      // 50 from IDLE: vend with 10 change; a coin during VEND is rejected
      coin(2'b10);
      check("c50_z", 32'(z), 1);
      check("c50_change", 32'(change), 1);
      check("c50_amt", 32'(change_amt), 10);
      check("c50_credit", 32'(credit), 50);
      coin(2'b00);
      check("vend_coin_reject", 32'(coin_reject), 1);
      check("vend_coin_credit", 32'(credit), 0);
      check("c50_change_after", 32'(change), 0);
      check("c50_amt_after", 32'(change_amt), 0);
      tick();
      check("reject_cleared", 32'(coin_reject), 0);

      // Cancel in IDLE without a coin is ignored
      Cancel = 1'b1; tick(); Cancel = 1'b0;
      check("idle_cancel_change", 32'(change), 0);
      check("idle_cancel_busy", 32'(busy), 0);

      // 20 then Cancel -> refund 20
      coin(2'b01); check("r20_credit", 32'(credit), 20);
      Cancel = 1'b1; tick(); Cancel = 1'b0;
      check("r20_change", 32'(change), 1);
      check("r20_amt", 32'(change_amt), 20);
      check("r20_z", 32'(z), 0);
      check("r20_busy", 32'(busy), 1);
      tick();
      check("r20_credit_after", 32'(credit), 0);
      check("r20_change_after", 32'(change), 0);

      // 10 + 20, then Cancel with a 100 coin -> refund 130, no vend
      coin(2'b00); coin(2'b01);
      check("r130_pre_credit", 32'(credit), 30);
      Cancel = 1'b1; coin(2'b11); Cancel = 1'b0;
      check("r130_change", 32'(change), 1);
      check("r130_amt", 32'(change_amt), 130);
      check("r130_z", 32'(z), 0);
      tick();
      check("r130_credit_after", 32'(credit), 0);

      // Async reset mid-COLLECT, asserted and released between edges
      coin(2'b00); coin(2'b01);
      check("mid_credit", 32'(credit), 30);
      #3 Reset = 1'b1;
      #1;
      check("async_credit", 32'(credit), 0);
      check("async_z", 32'(z), 0);
      check("async_change", 32'(change), 0);
      check("async_busy", 32'(busy), 0);
      @(posedge Clk);
      #2 Reset = 1'b0;
      tick();
      check("post_rst_credit", 32'(credit), 0);
      check("post_rst_change", 32'(change), 0);
      tick();
      check("post_rst_change2", 32'(change), 0);

      // One-item stock: vend, sold out, reject, restock, accept again
      coin(2'b10);
      check("s1_z", 32'(z1), 1);
      check("s1_amt", 32'(change_amt1), 10);
      tick();
      check("s1_soldout", 32'(sold_out1), 1);
      coin(2'b00);
      check("s1_reject", 32'(coin_reject1), 1);
      check("s1_reject_credit", 32'(credit1), 0);
      Restock = 1'b1; tick(); Restock = 1'b0;
      tick();
      check("s1_restock_soldout", 32'(sold_out1), 0);
      coin(2'b00);
      check("s1_accept_credit", 32'(credit1), 10);
      check("s1_accept_reject", 32'(coin_reject1), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
Parametrised vending controller. It is the next generation of the team's fixed-price, three-coin vending FSM. It adds a credit accumulator instead of one state per amount, a configurable price and four coin values, a binary change amount, cancel/refund, a coin-accept handshake, and a stock counter with sold-out lockout. It sits between the coin-acceptor front end and the dispense/change actuators.

Parameters:
CREDIT_W, 8, width of the credit and change datapath in currency units
PRICE, 40, item price in currency units
COIN0, 10, value of Money code 2'b00
COIN1, 20, value of Money code 2'b01
COIN2, 50, value of Money code 2'b10
COIN3, 100, value of Money code 2'b11
STOCK_W, 4, width of the stock counter
STOCK_INIT, 8, stock value loaded at reset and on Restock

Ports:
Clk  input  1  clock
Reset  input  1  asynchronous, active-high reset
Money  input  2  coin code, qualified by Coin_Valid
Coin_Valid  input  1  one-cycle strobe: a coin is presented on Money
Cancel  input  1  level; request refund of current credit
Restock  input  1  one-cycle strobe; reload stock to STOCK_INIT
Z  output  1  dispense pulse, one cycle
Change  output  1  change/refund pulse, one cycle
Change_Amt  output  CREDIT_W  amount to return; valid while Change=1, else 0
Credit  output  CREDIT_W  current accumulated credit
Coin_Reject  output  1  one-cycle pulse: the presented coin was not accepted
Sold_Out  output  1  high while stock == 0
Busy  output  1  high in VEND or REFUND

Behaviour:
- All outputs are registered.
- Reset (async, any state, mid-transaction included) forces:
  - state IDLE; credit 0; stock STOCK_INIT.
  - Z, Change, Change_Amt, Coin_Reject, Busy all 0.
  - Sold_Out = (STOCK_INIT == 0).
  - Credit already accumulated is lost; no refund is issued.
- States: IDLE (credit 0), COLLECT (0 < credit < PRICE), VEND, REFUND. VEND and REFUND each last exactly one cycle, then return to IDLE with credit 0.
- Coin value: Money decodes to COINn.
- A coin is accepted when Coin_Valid=1, state is IDLE or COLLECT, and Sold_Out=0. Otherwise Coin_Reject=1 in the following cycle and the coin is not added.
- Accepted coin: sum = credit + value.
  - If sum < PRICE: credit <= sum; state is COLLECT.
  - If sum >= PRICE: state <= VEND and Credit shows sum.
- VEND cycle:
  - Z=1; Busy=1.
  - Change=1 iff sum > PRICE; Change_Amt = sum − PRICE when Change=1, else 0.
  - stock decrements by 1.
  - On the next edge: credit 0, state IDLE.
- Latency: the completing coin is sampled at edge k; Z and Change are high for the single cycle between edges k and k+1.
- Cancel:
  - Sampled in COLLECT, or in IDLE with an accepted coin in the same cycle: REFUND with Change=1, Change_Amt = credit (plus the same-cycle coin), Z=0.
  - Cancel in IDLE with no coin: ignored.
  - Cancel and a completing coin in the same cycle: Cancel wins, full refund of credit + coin, no vend.
- Restock:
  - Honoured only in IDLE: stock <= STOCK_INIT, Sold_Out clears on the next cycle.
  - Ignored in any other state.
- Sold_Out:
  - Updates the cycle after stock reaches 0.
  - A COLLECT transaction already in progress may still be cancelled.
  - Further coins are rejected; no vend occurs.
- Width rules: CREDIT_W must hold PRICE − 1 + max(COINn). This is checked by an elaboration-time assertion; no saturation logic. Stock never decrements below 0.
- Coin_Valid during VEND/REFUND: rejected, no credit effect.

Test Plan:
- Reset, then coins 10,10,20 on separate Coin_Valid strobes -> Credit 10, 20; Z=1 one cycle after the third coin, Change=0, stock 8→7, Credit 0 afterwards.
- Coin 50 from IDLE -> Z=1 and Change=1 in the same cycle, Change_Amt=10; then Change_Amt returns to 0.
- Coin 20 then Cancel -> REFUND: Change=1, Change_Amt=20, Z=0; back to IDLE, Credit 0.
- Coin 30 via 10+20, then Cancel together with a 100 coin -> refund Change_Amt=130, no Z, stock unchanged.
- STOCK_INIT=1: vend once -> Sold_Out=1; next coin gives Coin_Reject pulse, Credit stays 0; Restock in IDLE -> Sold_Out=0 and coins are accepted again.
- Reset asserted mid-COLLECT (credit 30) and between clock edges -> all outputs 0 immediately; Credit 0, no Change pulse after release.
